// File: rtl/led_sweep_decoder_pkg.sv
// Shared types for the LED sweep decoder: FSM states, LED pattern classes, bar size.
// Imported by the classifier and the top-level decoder.
package led_sweep_decoder_pkg;

  localparam int LED_COUNT = 10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACQUIRE    = 2'd1,
    TRACK_UP   = 2'd2,
    TRACK_DOWN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    ONEHOT = 2'd1,
    MULTI  = 2'd2
  } pat_class_t;

endpackage

// File: rtl/led_sweep_decoder_onehot_classifier.sv
// Combinational LED pattern classifier: none / exactly one / several bits lit.
// Zero latency, no flow control; idx is meaningful only when pat_class is ONEHOT.
module led_sweep_decoder_onehot_classifier
  import led_sweep_decoder_pkg::*;
#(
  parameter int N_LEDS = LED_COUNT,
  parameter int POS_W  = 4
) (
  input  logic [N_LEDS-1:0] leds,
  output pat_class_t        pat_class,
  output logic [POS_W-1:0]  idx
);

  logic any_set;
  logic multi_set;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign any_set   = |leds;
  assign multi_set = |(leds & (leds - {{(N_LEDS-1){1'b0}}, 1'b1}));

  always_comb begin
    pat_class = ZERO;
    if (multi_set) begin
      pat_class = MULTI;
    end else if (any_set) begin
      pat_class = ONEHOT;
    end
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (leds[i]) begin
        idx = POS_W'(i);
      end
    end
  end

endmodule

// File: rtl/led_sweep_decoder.sv
// Tracks a bouncing single-lit LED bar: position, direction, bounce count, illegal-pattern flags.
// Outputs registered one clock after a sample_en cycle; everything holds while sample_en is low.
module led_sweep_decoder
  import led_sweep_decoder_pkg::*;
#(
  parameter int N_LEDS = LED_COUNT,
  parameter int POS_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [N_LEDS-1:0] leds,
  input  logic              clear_err,
  output logic [POS_W-1:0]  position,
  output logic              dir_up,
  output logic              locked,
  output logic [CNT_W-1:0]  bounce_count,
  output logic              error,
  output logic              err_sticky
);

  localparam logic [POS_W-1:0] POS_TOP  = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] POS_NEAR = POS_W'(N_LEDS - 2);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  pat_class_t       pat_class;
  logic [POS_W-1:0] p;

  state_t           state, state_n;
  logic [POS_W-1:0] position_n;
  logic             dir_up_n;
  logic             locked_n;
  logic [CNT_W-1:0] bounce_count_n;
  logic             bad;
  logic             err_sticky_n;

  logic same, step_up, step_dn;

  led_sweep_decoder_onehot_classifier #(
    .N_LEDS (N_LEDS),
    .POS_W  (POS_W)
  ) u_classifier (
    .leds      (leds),
    .pat_class (pat_class),
    .idx       (p)
  );

  // Widened compare for the upward step so q+1 never aliases back to 0.
  assign same    = (p == position);
  assign step_up = ({1'b0, p} == ({1'b0, position} + {{POS_W{1'b0}}, 1'b1}));
  assign step_dn = (position != '0) && (p == (position - POS_ONE));

  always_comb begin
    state_n        = state;
    position_n     = position;
    dir_up_n       = dir_up;
    locked_n       = locked;
    bounce_count_n = bounce_count;
    bad            = 1'b0;

    if (sample_en) begin
      case (pat_class)
        ZERO: begin
          state_n  = IDLE;
          locked_n = 1'b0;
        end
        MULTI: begin
          bad      = 1'b1;
          state_n  = IDLE;
          locked_n = 1'b0;
        end
        default: begin
          position_n = p;
          case (state)
            IDLE: begin
              state_n = ACQUIRE;
            end
            ACQUIRE: begin
              if (!same) begin
                if (step_up) begin
                  state_n  = TRACK_UP;
                  dir_up_n = 1'b1;
                  locked_n = 1'b1;
                end else if (step_dn) begin
                  state_n  = TRACK_DOWN;
                  dir_up_n = 1'b0;
                  locked_n = 1'b1;
                end else begin
                  bad = 1'b1;
                end
              end
            end
            TRACK_UP: begin
              if (!same) begin
                if (step_up && (position != POS_TOP)) begin
                  state_n = TRACK_UP;
                end else if ((position == POS_TOP) && (p == POS_NEAR)) begin
                  state_n        = TRACK_DOWN;
                  dir_up_n       = 1'b0;
                  bounce_count_n = bounce_count + 1'b1;
                end else begin
                  bad = 1'b1;
                end
              end
            end
            TRACK_DOWN: begin
              if (!same) begin
                if (step_dn) begin
                  state_n = TRACK_DOWN;
                end else if ((position == '0) && (p == POS_ONE)) begin
                  state_n        = TRACK_UP;
                  dir_up_n       = 1'b1;
                  bounce_count_n = bounce_count + 1'b1;
                end else begin
                  bad = 1'b1;
                end
              end
            end
            default: begin
              state_n = IDLE;
            end
          endcase
          if (bad) begin
            state_n  = IDLE;
            locked_n = 1'b0;
          end
        end
      endcase
    end

    // A fresh error outranks a simultaneous clear.
    if (bad) begin
      err_sticky_n = 1'b1;
    end else if (clear_err) begin
      err_sticky_n = 1'b0;
    end else begin
      err_sticky_n = err_sticky;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      position     <= '0;
      dir_up       <= 1'b1;
      locked       <= 1'b0;
      bounce_count <= '0;
      error        <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      state        <= state_n;
      position     <= position_n;
      dir_up       <= dir_up_n;
      locked       <= locked_n;
      bounce_count <= bounce_count_n;
      error        <= bad;
      err_sticky   <= err_sticky_n;
    end
  end

endmodule

// File: tb/tb_led_sweep_decoder.sv
// Scoreboard bench for led_sweep_decoder: stimulus queues hand-computed expectations,
// a monitor pops one per checked cycle and compares the full output bundle.
module tb_led_sweep_decoder;

  typedef struct packed {
    logic [3:0] pos;
    logic       dir;
    logic       lock;
    logic [7:0] bc;
    logic       err;
    logic       st;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       sample_en;
  logic [9:0] leds;
  logic       clear_err;
  logic [3:0] position;
  logic       dir_up;
  logic       locked;
  logic [7:0] bounce_count;
  logic       error;
  logic       err_sticky;

  logic       chk;
  exp_t       ex;
  exp_t       exp_q[$];
  string      name_q[$];
  int         tests;
  int         fails;

  led_sweep_decoder dut (
    .clock        (clock),
    .reset        (reset),
    .sample_en    (sample_en),
    .leds         (leds),
    .clear_err    (clear_err),
    .position     (position),
    .dir_up       (dir_up),
    .locked       (locked),
    .bounce_count (bounce_count),
    .error        (error),
    .err_sticky   (err_sticky)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input logic rst, input logic se, input logic [9:0] l,
                      input logic ce, input string nm);
    @(negedge clock);
    reset     = rst;
    sample_en = se;
    leds      = l;
    clear_err = ce;
    chk       = 1'b1;
    exp_q.push_back(ex);
    name_q.push_back(nm);
  endtask

  function automatic logic [9:0] bit_at(input int i);
    logic [9:0] one;
    one = 10'd1;
    return one << i;
  endfunction

  // Monitor: outputs for a checked cycle are valid just after the following edge.
  initial begin
    exp_t  a;
    exp_t  e;
    string n;
    logic  c;
    forever begin
      @(posedge clock);
      c = chk;
      #1;
      if (c === 1'b1) begin
        tests++;
        a = {position, dir_up, locked, bounce_count, error, err_sticky};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL no_expectation: got pos=%0d dir=%0b lock=%0b bc=%0d err=%0b st=%0b",
                   a.pos, a.dir, a.lock, a.bc, a.err, a.st);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (a !== e) begin
            fails++;
            $display("FAIL %s: got pos=%0d dir=%0b lock=%0b bc=%0d err=%0b st=%0b, want pos=%0d dir=%0b lock=%0b bc=%0d err=%0b st=%0b",
                     n, a.pos, a.dir, a.lock, a.bc, a.err, a.st,
                     e.pos, e.dir, e.lock, e.bc, e.err, e.st);
          end
        end
      end
    end
  end

  initial begin
    int p;
    int d;
    int nb;
    int waited;
    tests     = 0;
    fails     = 0;
    chk       = 1'b0;
    reset     = 1'b1;
    sample_en = 1'b0;
    leds      = '0;
    clear_err = 1'b0;

    // Reset values
    ex = '{pos: 4'd0, dir: 1'b1, lock: 1'b0, bc: 8'd0, err: 1'b0, st: 1'b0};
    step(1, 0, 10'h000, 0, "reset");
    step(1, 0, 10'h000, 0, "reset_hold");

    // Full sweep 0..9..0,1
    for (int i = 0; i <= 9; i++) begin
      ex.pos  = 4'(i);
      ex.lock = (i >= 1);
      step(0, 1, bit_at(i), 0, "sweep_up");
    end
    for (int i = 8; i >= 0; i--) begin
      ex.pos = 4'(i);
      ex.dir = 1'b0;
      ex.bc  = 8'd1;
      step(0, 1, bit_at(i), 0, "sweep_down");
    end
    ex.pos = 4'd1; ex.dir = 1'b1; ex.bc = 8'd2;
    step(0, 1, 10'h002, 0, "bounce_bottom");

    // ZERO -> IDLE, position held
    ex.lock = 1'b0;
    step(0, 1, 10'h000, 0, "zero_off");

    // Acquire hold at 4, then step to 5
    ex.pos = 4'd4;
    step(0, 1, 10'h010, 0, "acq_first");
    step(0, 1, 10'h010, 0, "acq_hold1");
    step(0, 1, 10'h010, 0, "acq_hold2");
    ex.pos = 4'd5; ex.lock = 1'b1; ex.dir = 1'b1;
    step(0, 1, 10'h020, 0, "acq_lock_up");

    // Mid-bar reversal while tracking up
    ex.pos = 4'd4; ex.lock = 1'b0; ex.err = 1'b1; ex.st = 1'b1;
    step(0, 1, 10'h010, 0, "reverse_err");
    ex.err = 1'b0;
    step(0, 0, 10'h010, 0, "err_pulse_end");
    ex.st = 1'b0;
    step(0, 0, 10'h010, 1, "clear_err");

    // MULTI while tracking down
    ex.pos = 4'd4;
    step(0, 1, 10'h010, 0, "reacq_4");
    ex.pos = 4'd3; ex.dir = 1'b0; ex.lock = 1'b1;
    step(0, 1, 10'h008, 0, "lock_down");
    ex.lock = 1'b0; ex.err = 1'b1; ex.st = 1'b1;
    step(0, 1, 10'h003, 0, "multi_err");

    // ZERO mid-sweep
    ex.pos = 4'd2; ex.err = 1'b0;
    step(0, 1, 10'h004, 0, "reacq_2");
    ex.pos = 4'd1; ex.lock = 1'b1;
    step(0, 1, 10'h002, 0, "lock_down2");
    ex.lock = 1'b0;
    step(0, 1, 10'h000, 0, "zero_midsweep");
    ex.st = 1'b0;
    step(0, 0, 10'h000, 1, "clear_err2");

    // LEDs churn without sample_en
    step(0, 0, 10'h3FF, 0, "nosample_all");
    step(0, 0, 10'h003, 0, "nosample_multi");
    for (int k = 0; k < 18; k++) begin
      step(0, 0, 10'($urandom_range(0, 1023)), 0, "nosample_rand");
    end

    // Build bounce_count=3, then reset mid-sweep
    ex.pos = 4'd0;
    step(0, 1, 10'h001, 0, "acq_0");
    for (int i = 1; i <= 9; i++) begin
      ex.pos = 4'(i); ex.lock = 1'b1; ex.dir = 1'b1;
      step(0, 1, bit_at(i), 0, "run_up");
    end
    ex.pos = 4'd8; ex.dir = 1'b0; ex.bc = 8'd3;
    step(0, 1, 10'h100, 0, "bounce_top3");
    ex.pos = 4'd7;
    step(0, 1, 10'h080, 0, "run_down");
    ex = '{pos: 4'd0, dir: 1'b1, lock: 1'b0, bc: 8'd0, err: 1'b0, st: 1'b0};
    step(1, 1, 10'h3FF, 1, "reset_midsweep");

    // 256 bounces -> wrap to 0
    step(0, 1, 10'h001, 0, "wrap_acq");
    ex.pos = 4'd1; ex.lock = 1'b1;
    step(0, 1, 10'h002, 0, "wrap_lock");
    p = 1; d = 1; nb = 0;
    while (nb < 256) begin
      if (d == 1 && p == 9) begin
        p = 8; d = 0; nb++;
      end else if (d == 0 && p == 0) begin
        p = 1; d = 1; nb++;
      end else begin
        p = (d == 1) ? p + 1 : p - 1;
      end
      ex.pos = 4'(p);
      ex.dir = d[0];
      ex.bc  = nb[7:0];
      step(0, 1, bit_at(p), 0, "wrap_run");
    end

    // Illegal step together with clear_err: set wins
    ex.pos = 4'd0; ex.lock = 1'b0; ex.err = 1'b1; ex.st = 1'b1;
    step(0, 1, 10'h001, 1, "clear_vs_set");
    ex.err = 1'b0;
    step(0, 0, 10'h001, 0, "sticky_hold");

    @(negedge clock);
    chk       = 1'b0;
    sample_en = 1'b0;
    clear_err = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_sweep_decoder.md
Name: led_sweep_decoder

Overview:
Receive-side counterpart of the LED bar flasher. It samples a bouncing single-lit LED bar (10-bit LEDR-style vector) on each divider tick. It recovers lamp position and sweep direction, counts completed end-to-end bounces, and flags any pattern a correct flasher can never produce. It sits beside the flasher on the DE1-SoC build as a self-checker, fed by the same divide-by-N tick.

Parameters:
N_LEDS, 10, width of the LED bar; positions 0..N_LEDS-1, bit 0 = position 0
POS_W, 4, position width, ceil(log2(N_LEDS))
CNT_W, 8, width of bounce counter

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
sample_en  in  1  one-cycle strobe; LED vector evaluated only when high
leds  in  N_LEDS  LED bar pattern under test
clear_err  in  1  synchronous clear of err_sticky
position  out  POS_W  index of lit LED at last valid sample
dir_up  out  1  1 = moving toward N_LEDS-1, 0 = toward 0
locked  out  1  direction established and tracking
bounce_count  out  CNT_W  number of end reversals seen while locked
error  out  1  one-cycle pulse on illegal pattern/step
err_sticky  out  1  latched error until reset or clear_err

Behaviour:
- Reset (synchronous, active-high) wins over everything. Reset values: state=IDLE, position=0, dir_up=1, locked=0, bounce_count=0, error=0, err_sticky=0.
- All outputs are registered. Outputs reflect a sample one clock after the sample_en cycle. When sample_en=0, state and outputs hold, and error=0.
- Pattern classes per sample:
  - ZERO: all bits 0.
  - ONEHOT: exactly one bit set, with index p.
  - MULTI: two or more bits set.
- States: IDLE, ACQUIRE, TRACK_UP, TRACK_DOWN. Let q = stored position.
- In any state:
  - ZERO: go to IDLE, locked=0, no error (flasher switched off). Position holds.
  - MULTI: error pulse, err_sticky=1, go to IDLE, locked=0.
- IDLE + ONEHOT: position=p, go to ACQUIRE.
- ACQUIRE + ONEHOT:
  - p==q: hold.
  - p==q+1: TRACK_UP, dir_up=1, locked=1.
  - p==q-1: TRACK_DOWN, dir_up=0, locked=1.
  - else: error, go to IDLE.
- TRACK_UP + ONEHOT:
  - p==q: hold (sampling faster than flasher is legal).
  - p==q+1 with q<N_LEDS-1: advance.
  - q==N_LEDS-1 and p==N_LEDS-2: TRACK_DOWN, dir_up=0, bounce_count+1.
  - anything else (mid-bar reversal, skip, jump): error, go to IDLE, locked=0.
- TRACK_DOWN + ONEHOT: mirror image of TRACK_UP. Reversal is legal only at q==0 and p==1, and increments bounce_count.
- position updates to p on every ONEHOT sample, including the erroring one.
- bounce_count wraps modulo 2^CNT_W. It is not cleared by ZERO or error, only by reset.
- clear_err and a new error in the same cycle: err_sticky=1 (set wins).
- No error pulse is generated while sample_en=0.

Decomposition:
- Shared package: state enum (IDLE, ACQUIRE, TRACK_UP, TRACK_DOWN), LED_COUNT=10 constant, pattern-class enum (ZERO, ONEHOT, MULTI).
- One sub-module: onehot_classifier, combinational. Input leds; outputs class and index p. Index is don't-care unless class is ONEHOT.
- Top-level FSM, counters and sticky logic live in led_sweep_decoder.

Test Plan:
- Reset, then sweep 0,1,...,9,8,...,0,1 with one sample_en per step -> locked=1 after 2nd sample, dir_up=0 after the 9->8 sample, bounce_count=2 after the 0->1 sample, error never asserted.
- Hold leds=0x010 for 3 samples, then 0x020 -> stays in ACQUIRE with position=4, then TRACK_UP with position=5, no error.
- While tracking up at position 5, present 0x010 (pos 4) -> error single-cycle pulse, err_sticky=1, locked=0, state IDLE. Then clear_err -> err_sticky=0.
- Present 0x003 (MULTI) during TRACK_DOWN -> error pulse, IDLE. Present 0x000 mid-sweep -> IDLE, locked=0, error stays 0, bounce_count unchanged.
- Change leds without sample_en for 20 cycles, including illegal values -> all outputs unchanged. Assert reset mid-sweep with bounce_count=3 -> next cycle all outputs at reset values.
- Drive 256 bounces -> bounce_count wraps to 0. Apply clear_err in the same cycle as an illegal step -> err_sticky remains 1.
